// File: rtl/ec2_io_host.sv
// Host-side I/O sequencer: queues bytes for the processor, hands them over one per
// Enter pulse, and captures the processor Output when it halts.
module ec2_io_host #(
  parameter logic [3:0] INPUT_STATE = 4'd5,
  parameter int         DEPTH       = 4
) (
  input  logic       Clock,
  input  logic       Reset,
  input  logic       start,
  input  logic       wr_en,
  input  logic [7:0] wr_data,
  input  logic       Halt,
  input  logic [7:0] Output,
  input  logic [3:0] ProcState,
  output logic       Enter,
  output logic [7:0] Input,
  output logic       Initialize,
  output logic [7:0] result,
  output logic       done,
  output logic       full,
  output logic       empty,
  output logic       overflow,
  output logic [15:0] cycles,
  output logic [2:0] dbg_state
);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    INIT    = 3'd1,
    WAIT    = 3'd2,
    PRESENT = 3'd3,
    GAP     = 3'd4,
    DONE    = 3'd5
  } state_t;

  state_t     state;
  logic [7:0] mem [DEPTH];
  logic [1:0] wr_ptr;
  logic [1:0] rd_ptr;
  logic [2:0] count;
  logic       pop;
  logic       push;

  assign dbg_state = state;
  assign full      = (count == 3'(DEPTH));
  assign empty     = (count == 3'd0);

  // The head is consumed only on the edge that leaves PRESENT, so Input stays stable.
  assign pop  = (state == PRESENT) && !Halt && (ProcState == INPUT_STATE);
  assign push = wr_en && (!full || pop);

  always_ff @(posedge Clock) begin
    if (push) mem[wr_ptr] <= wr_data;
  end

  always_ff @(posedge Clock) begin
    if (!Reset) begin
      wr_ptr   <= 2'd0;
      rd_ptr   <= 2'd0;
      count    <= 3'd0;
      overflow <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 2'd1;
      if (pop)  rd_ptr <= rd_ptr + 2'd1;
      if (push && !pop)      count <= count + 3'd1;
      else if (pop && !push) count <= count - 3'd1;
      if (wr_en && full && !pop) overflow <= 1'b1;
    end
  end

  always_ff @(posedge Clock) begin
    if (!Reset) begin
      state      <= IDLE;
      Enter      <= 1'b0;
      Input      <= 8'h00;
      Initialize <= 1'b0;
      result     <= 8'h00;
      done       <= 1'b0;
      cycles     <= 16'h0000;
    end else begin
      if ((state == WAIT || state == PRESENT || state == GAP) && cycles != 16'hFFFF)
        cycles <= cycles + 16'd1;
      case (state)
        IDLE, DONE: begin
          if (start) begin
            state      <= INIT;
            Initialize <= 1'b1;
            done       <= 1'b0;
            cycles     <= 16'h0000;
          end
        end
        INIT: begin
          Initialize <= 1'b0;
          state      <= WAIT;
        end
        WAIT: begin
          if (Halt) begin
            state  <= DONE;
            result <= Output;
            done   <= 1'b1;
          end else if (!empty) begin
            state <= PRESENT;
            Enter <= 1'b1;
            Input <= mem[rd_ptr];
          end
        end
        PRESENT: begin
          if (Halt) begin
            state  <= DONE;
            result <= Output;
            done   <= 1'b1;
            Enter  <= 1'b0;
            Input  <= 8'h00;
          end else if (ProcState == INPUT_STATE) begin
            state <= GAP;
            Enter <= 1'b0;
            Input <= 8'h00;
          end
        end
        GAP: begin
          state <= WAIT;
        end
        default: begin
          state <= IDLE;
          Enter <= 1'b0;
          Input <= 8'h00;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ec2_io_host.sv
// Directed bench for ec2_io_host: reset, byte hand-over, FIFO full/overflow/wrap,
// halt capture and cycle-counter saturation.
module tb_ec2_io_host;

  localparam logic [2:0] S_IDLE = 3'd0, S_INIT = 3'd1, S_WAIT = 3'd2,
                         S_PRESENT = 3'd3, S_GAP = 3'd4, S_DONE = 3'd5;

  logic        Clock = 1'b0;
  logic        Reset = 1'b0;
  logic        start = 1'b0;
  logic        wr_en = 1'b0;
  logic [7:0]  wr_data = 8'h00;
  logic        Halt = 1'b0;
  logic [7:0]  Output = 8'h00;
  logic [3:0]  ProcState = 4'd0;
  logic        Enter;
  logic [7:0]  Input;
  logic        Initialize;
  logic [7:0]  result;
  logic        done;
  logic        full;
  logic        empty;
  logic        overflow;
  logic [15:0] cycles;
  logic [2:0]  dbg_state;

  int n_vec = 0;
  int n_err = 0;

  ec2_io_host #(.INPUT_STATE(4'd5)) dut (
    .Clock(Clock), .Reset(Reset), .start(start), .wr_en(wr_en), .wr_data(wr_data),
    .Halt(Halt), .Output(Output), .ProcState(ProcState), .Enter(Enter), .Input(Input),
    .Initialize(Initialize), .result(result), .done(done), .full(full), .empty(empty),
    .overflow(overflow), .cycles(cycles), .dbg_state(dbg_state)
  );

  always #5 Clock = ~Clock;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Inputs change and outputs are sampled 1ns after the rising edge.
  task automatic tick();
    @(posedge Clock);
    #1;
  endtask

  task automatic do_reset();
    Reset = 1'b0;
    tick();
    Reset = 1'b1;
  endtask

  task automatic push_byte(input logic [7:0] b);
    wr_en = 1'b1;
    wr_data = b;
    tick();
    wr_en = 1'b0;
  endtask

  task automatic run_to_wait();
    start = 1'b1;
    tick();
    check("init_state", dbg_state, S_INIT);
    check("init_pulse", Initialize, 1'b1);
    start = 1'b0;
    tick();
    check("wait_state", dbg_state, S_WAIT);
    check("init_low", Initialize, 1'b0);
  endtask

  // Called in PRESENT: accept the byte, walk through GAP and WAIT.
  task automatic take_byte(input string tag, input logic [7:0] exp);
    check({tag, "_enter"}, Enter, 1'b1);
    check({tag, "_input"}, Input, exp);
    ProcState = 4'd5;
    tick();
    ProcState = 4'd0;
    check({tag, "_gap"}, dbg_state, S_GAP);
    check({tag, "_gap_enter"}, Enter, 1'b0);
    check({tag, "_gap_input"}, Input, 8'h00);
    tick();
    tick();
  endtask

  initial begin
    tick();
    do_reset();
    check("rst_state", dbg_state, S_IDLE);
    check("rst_outs", {Enter, Input, Initialize, result, done}, 19'h0);
    check("rst_fifo", {empty, full, overflow, cycles}, {3'b100, 16'h0});

    // Reset while presenting with two bytes queued
    push_byte(8'h01);
    push_byte(8'h02);
    run_to_wait();
    tick();
    check("pre_rst_present", dbg_state, S_PRESENT);
    Reset = 1'b0;
    start = 1'b1;
    wr_en = 1'b1;
    Halt = 1'b1;
    tick();
    start = 1'b0;
    wr_en = 1'b0;
    Halt = 1'b0;
    Reset = 1'b1;
    check("midrst_state", dbg_state, S_IDLE);
    check("midrst_outs", {Enter, Input, empty, done}, {1'b0, 8'h00, 1'b1, 1'b0});

    // Two-byte hand-over, then halt during PRESENT
    push_byte(8'h12);
    push_byte(8'h34);
    run_to_wait();
    start = 1'b1;
    tick();
    start = 1'b0;
    check("present1", dbg_state, S_PRESENT);
    take_byte("b12", 8'h12);
    check("present2", dbg_state, S_PRESENT);
    check("b34_input", Input, 8'h34);
    check("b34_enter", Enter, 1'b1);
    Output = 8'h5C;
    Halt = 1'b1;
    tick();
    Halt = 1'b0;
    Output = 8'h00;
    check("halt_state", dbg_state, S_DONE);
    check("halt_result", result, 8'h5C);
    check("halt_done", done, 1'b1);
    check("halt_enter", {Enter, Input}, 9'h0);
    check("halt_nopop", empty, 1'b0);
    tick();
    check("done_hold", {dbg_state, result, done}, {S_DONE, 8'h5C, 1'b1});

    // Fill past capacity with no pops
    do_reset();
    for (int i = 0; i < 5; i++) begin
      push_byte(8'hA0 + 8'(i));
      if (i == 2) check("fill3_full", full, 1'b0);
      if (i == 3) check("fill4", {full, overflow}, 2'b10);
      if (i == 4) check("fill5", {full, overflow}, 2'b11);
    end
    run_to_wait();
    tick();
    take_byte("ov0", 8'hA0);
    take_byte("ov1", 8'hA1);
    take_byte("ov2", 8'hA2);
    take_byte("ov3", 8'hA3);
    check("ov_drained", {dbg_state, empty}, {S_WAIT, 1'b1});

    // Push into a full FIFO on the same edge as a pop
    do_reset();
    for (int i = 0; i < 4; i++) push_byte(8'hB0 + 8'(i));
    run_to_wait();
    tick();
    check("wrap_input", Input, 8'hB0);
    ProcState = 4'd5;
    wr_en = 1'b1;
    wr_data = 8'hAA;
    tick();
    wr_en = 1'b0;
    ProcState = 4'd0;
    check("wrap_full", {full, overflow, dbg_state}, {1'b1, 1'b0, S_GAP});
    tick();
    tick();
    take_byte("wr1", 8'hB1);
    take_byte("wr2", 8'hB2);
    take_byte("wr3", 8'hB3);
    take_byte("wr4", 8'hAA);
    check("wrap_empty", empty, 1'b1);

    // Cycle counter saturation and restart from DONE
    do_reset();
    run_to_wait();
    start = 1'b1;
    tick();
    start = 1'b0;
    check("start_ignored", dbg_state, S_WAIT);
    check("cycles_one", cycles, 16'd1);
    for (int i = 0; i < 70000; i++) tick();
    check("cycles_sat", cycles, 16'hFFFF);
    Halt = 1'b1;
    tick();
    Halt = 1'b0;
    check("sat_done", {dbg_state, done, cycles}, {S_DONE, 1'b1, 16'hFFFF});
    start = 1'b1;
    tick();
    start = 1'b0;
    check("restart", {dbg_state, Initialize, done, cycles}, {S_INIT, 1'b1, 1'b0, 16'h0});
    tick();
    check("restart_wait", {dbg_state, Initialize}, {S_WAIT, 1'b0});

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/ec2_io_host.md
EC2_IO_HOST -- requirements
Module: ec2_io_host

Parameters
REQ-001 SHALL have parameter INPUT_STATE, default 4'd5: processor state code in which Enter/Input are sampled.
REQ-002 SHALL have parameter DEPTH, fixed at 4: input FIFO entries.

Interface
REQ-003 Clock  input  1  sole clock; all state updates on rising edge.
REQ-004 Reset  input  1  synchronous, active-low reset.
REQ-005 start  input  1  host command: begin or re-begin a program run.
REQ-006 wr_en  input  1  host push of wr_data into the input FIFO.
REQ-007 wr_data  input  8  byte to queue for the processor.
REQ-008 Halt  input  1  processor halted.
REQ-009 Output  input  8  processor output bus.
REQ-010 ProcState  input  4  processor current state.
REQ-011 Enter  output  1  input-valid strobe to the processor.
REQ-012 Input  output  8  byte presented to the processor.
REQ-013 Initialize  output  1  processor initialize pulse.
REQ-014 result  output  8  Output value captured at halt.
REQ-015 done  output  1  run complete; result valid.
REQ-016 full, empty  output  1 each  FIFO status.
REQ-017 overflow  output  1  sticky: push attempted while full and not popping.
REQ-018 cycles  output  16  run-length counter.

Function
REQ-019 FSM states SHALL be IDLE, INIT, WAIT, PRESENT, GAP, DONE.
REQ-020 IDLE: start=1 -> INIT; otherwise stay.
REQ-021 INIT: Initialize=1 for exactly one cycle; clear done and cycles; -> WAIT. The FIFO is not cleared.
REQ-022 WAIT: Halt=1 -> DONE (priority); else FIFO non-empty -> PRESENT; else stay.
REQ-023 PRESENT: Enter=1, Input=FIFO head; Halt=1 -> DONE without pop; else ProcState==INPUT_STATE -> pop head, -> GAP.
REQ-024 GAP: Enter=0 for exactly one cycle; -> WAIT. Guarantees one byte per Enter pulse.
REQ-025 Enter SHALL be 1 only in PRESENT. Input SHALL be 8'h00 outside PRESENT.
REQ-026 DONE: on entry, result<=Output and done<=1; both hold until next INIT. start=1 -> INIT.
REQ-027 start SHALL be ignored in INIT, WAIT, PRESENT and GAP.
REQ-028 cycles SHALL increment by 1 each cycle in WAIT, PRESENT or GAP, and saturate at 16'hFFFF.
REQ-029 FIFO SHALL be circular, 2-bit read/write pointers wrapping 3->0, with a 3-bit count.
REQ-030 Push when not full SHALL store wr_data at wr_ptr; push when full without same-cycle pop SHALL be dropped and set overflow.
REQ-031 Simultaneous push and pop SHALL both take effect, including when full; count unchanged.
REQ-032 full=(count==4); empty=(count==0); both combinational from count.

Reset
REQ-033 Reset=0 at a rising edge SHALL force IDLE, with Enter=0, Input=0, Initialize=0, result=0, done=0, cycles=0, overflow=0, FIFO emptied (empty=1, full=0), from any state including mid-PRESENT.
REQ-034 Reset SHALL take priority over start, wr_en and Halt in the same cycle.

Verification
REQ-035 Reset=0 in PRESENT with 2 bytes queued -> next cycle state IDLE, Enter=0, empty=1, done=0.
REQ-036 Push 8'h12, 8'h34; start; ProcState=5 on first PRESENT cycle -> Input=8'h12 with Enter=1, then one GAP cycle Enter=0, then Input=8'h34 with Enter=1.
REQ-037 Push 5 bytes with no pops -> full=1 after fourth push, overflow=1 after fifth, FIFO holds first four in order.
REQ-038 FIFO full, push 8'hAA in the same cycle as a PRESENT pop -> count stays 4; 8'hAA is delivered fourth after wrap.
REQ-039 Run with Output=8'h5C, Halt=1 during PRESENT -> DONE next cycle, result=8'h5C, done=1, head not popped, Enter=0.
REQ-040 Hold in WAIT for 70000 cycles -> cycles=16'hFFFF; start in DONE -> Initialize pulses one cycle, cycles=0, done=0.
